// File: rtl/siso_pkg.sv
// Shared constants and types for the serial-in serial-out delay line.
package siso_pkg;

  localparam int   SISO_DEPTH_DEFAULT = 4;
  localparam int   SISO_DEPTH_MAX     = 64;
  localparam logic SISO_RST_VAL       = 1'b0;

  typedef logic [SISO_DEPTH_DEFAULT-1:0] siso_vec_t;

  function automatic bit siso_depth_ok(input int depth);
    return (depth >= 1) && (depth <= SISO_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/siso_stage.sv
// One delay-line cell: a D flip-flop with asynchronous active-high reset.
// Latency one clock; no backpressure, it captures d on every rising edge.
module siso_stage
  import siso_pkg::*;
#(
  parameter logic RST_VAL = SISO_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/siso.sv
// Serial-in serial-out shift register: delays a bit stream by DEPTH clocks.
// Shifts unconditionally every cycle; no backpressure, overflowing bits are dropped.
module siso
  import siso_pkg::*;
#(
  parameter int   DEPTH   = SISO_DEPTH_DEFAULT,
  parameter logic RST_VAL = SISO_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  if (!siso_depth_ok(DEPTH)) begin : g_bad_depth
    $error("siso: DEPTH=%0d outside legal range 1..%0d", DEPTH, SISO_DEPTH_MAX);
  end

  logic [DEPTH-1:0] stg;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      siso_stage #(.RST_VAL(RST_VAL)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (stg[g])
      );
    end else begin : g_tail
      siso_stage #(.RST_VAL(RST_VAL)) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (stg[g-1]),
        .q   (stg[g])
      );
    end
  end

  assign out = stg[DEPTH-1];

  // Edges seen since reset, saturating once the line holds only post-reset data.
  localparam logic [6:0] FILL_MAX = 7'(DEPTH);
  logic [6:0] fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   fill <= '0;
    else if (fill != FILL_MAX) fill <= fill + 7'd1;
  end

  a_delay : assert property (@(posedge clk) disable iff (rst)
    (fill == FILL_MAX) |-> (out == $past(in, DEPTH)));

endmodule

// File: tb/tb_siso.sv
// Scoreboarded bench for siso at DEPTH 1, 4 and 8 driven from a shared stream.
module tb_siso;

  localparam int N = 3;
  localparam int DEP [N] = '{1, 4, 8};

  logic clk, rst, in;
  logic o1, o4, o8;

  int checks = 0;
  int errors = 0;

  // Each line holds the bits still travelling through a DUT of that depth.
  bit line  [N][$];
  bit exp_q [N][$];

  siso #(.DEPTH(1), .RST_VAL(1'b0)) u_d1 (.clk(clk), .rst(rst), .in(in), .out(o1));
  siso #(.DEPTH(4), .RST_VAL(1'b0)) u_d4 (.clk(clk), .rst(rst), .in(in), .out(o4));
  siso #(.DEPTH(8), .RST_VAL(1'b0)) u_d8 (.clk(clk), .rst(rst), .in(in), .out(o8));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic dut_out(input int i);
    case (i)
      0:       return o1;
      1:       return o4;
      default: return o8;
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s depth=%0d t=%0t got=%b want=%b", name, DEP[i], $time, act, exp);
    end
  endtask

  // A bit appears DEPTH edges after being sampled; zeros fill the line after reset.
  function automatic void model_init();
    for (int i = 0; i < N; i++) begin
      line[i].delete();
      for (int k = 0; k < DEP[i] - 1; k++) line[i].push_back(1'b0);
    end
  endfunction

  function automatic void model_sample(input bit b);
    for (int i = 0; i < N; i++) begin
      line[i].push_back(b);
      exp_q[i].push_back(line[i].pop_front());
    end
  endfunction

  // Called at a falling edge; the next rising edge samples b.
  task automatic drive(input bit b);
    in = b;
    model_sample(b);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit pending_edge);
    if (pending_edge) model_sample(in);
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk("async_reset_now", i, dut_out(i), 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("reset_hold", i, dut_out(i), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  // Monitor: compare every post-edge output against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0) chk("stream", i, dut_out(i), exp_q[i].pop_front());
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    in  = 1'b0;
    rst = 1'b0;
    model_init();

    // Reset pulse, then in=0 keeps out at 0.
    #5 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) chk("power_on_reset", i, dut_out(i), 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("reset_hold0", i, dut_out(i), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_init();
    repeat (4) drive(1'b0);

    // Pattern 111010 then 300 units of zeros.
    foreach (pat[k]) drive(pat[k]);
    repeat (15) drive(1'b0);

    // Single-pulse latency.
    repeat (3) drive(1'b0);
    drive(1'b1);
    repeat (10) drive(1'b0);

    // Fill with ones, reset mid-stream, then confirm zeros until new data.
    repeat (4) drive(1'b1);
    do_reset(1'b1);
    repeat (10) drive(1'b0);
    repeat (3) drive(1'b1);
    repeat (9) drive(1'b0);

    // Alternating stream.
    repeat (16) begin
      drive(1'b1);
      drive(1'b0);
    end
    repeat (9) drive(1'b0);

    // Random stream with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset(1'b1);
      else                            drive(1'($urandom_range(0, 1)));
    end
    repeat (9) drive(1'b0);

    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) chk("scoreboard_drained", i, 1'(exp_q[i].size() == 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
